// File: rtl/y_vector_writer_pkg.sv
// Shared types and helpers for the y-vector writer.
// Holds the FloPoCo exception codes, the controller state encoding and
// the FloPoCo(66b) -> IEEE-754 double conversion used on every store.
package y_vector_writer_pkg;

    localparam int unsigned FP_W   = 66;
    localparam int unsigned DBL_W  = 64;
    localparam int unsigned ADDR_W = 48;
    localparam int unsigned ROW_W  = 32;

    localparam logic [1:0] FP_EXN_ZERO   = 2'b00;
    localparam logic [1:0] FP_EXN_NORMAL = 2'b01;
    localparam logic [1:0] FP_EXN_INF    = 2'b10;
    localparam logic [1:0] FP_EXN_NAN    = 2'b11;

    localparam logic [DBL_W-1:0] IEEE_QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } yw_state_e;

    // FloPoCo keeps zero/inf/nan in a 2-bit exception field; IEEE encodes them in exp/frac.
    function automatic logic [DBL_W-1:0] flopoco_to_ieee(input logic [FP_W-1:0] v);
        logic [DBL_W-1:0] r;
        r = IEEE_QNAN;
        case (v[65:64])
            FP_EXN_NORMAL: r = v[63:0];
            FP_EXN_ZERO:   r = {v[63], 63'b0};
            FP_EXN_INF:    r = {v[63], 11'h7FF, 52'b0};
            FP_EXN_NAN:    r = IEEE_QNAN;
            default:       r = IEEE_QNAN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/std_fifo.sv
// Synchronous single-clock FIFO with show-ahead read data.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clr             synchronous flush (same effect as reset on the pointers)
//   i_wr_en/i_wr_data write side; writes while full are dropped
//   i_rd_en           pop the head entry; ignored while empty
//   o_rd_data         head entry (valid when !o_empty)
//   o_full/o_empty    occupancy flags
//   o_almost_full     count >= AF_THRESH
//   o_count           current number of entries (0..DEPTH)
module std_fifo #(
    parameter int unsigned WIDTH     = 66,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_wr;
    logic w_do_rd;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_do_wr = i_wr_en && !w_full;
    assign w_do_rd = i_rd_en && !w_empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data     = r_mem[r_rd_ptr];
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_almost_full = (r_count >= CW'(AF_THRESH));
    assign o_count       = r_count;

endmodule

// File: rtl/y_vector_writer.sv
// Consumer end of the MAC y-result interface.
// Buffers finished row sums, converts them to IEEE-754 doubles and stores
// them one row per 8-byte write at consecutive addresses, then reports done
// once every store of the pass has been acknowledged by the memory controller.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, y_base, row_count pass control (start honoured in IDLE/DONE)
//   push_to_y, v_to_y        producer results; stall_out is the backpressure
//   mc_req_st/vadr/wrd       store request towards the memory controller
//   mc_wr_rq_stall           MC write-request stall
//   mc_wr_cmd_cmp            one store completion
//   busy, done               pass status
//   err_overflow             sticky: push while buffer full
//   err_unexpected           sticky: push outside RUN
module y_vector_writer
    import y_vector_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 64,
    parameter int unsigned STALL_MARGIN    = 8,
    parameter int unsigned MAX_OUTSTANDING = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] y_base,
    input  logic [ROW_W-1:0]  row_count,
    input  logic              push_to_y,
    input  logic [FP_W-1:0]   v_to_y,
    output logic              stall_out,
    output logic              mc_req_st,
    output logic [ADDR_W-1:0] mc_req_vadr,
    output logic [DBL_W-1:0]  mc_req_wrd,
    input  logic              mc_wr_rq_stall,
    input  logic              mc_wr_cmd_cmp,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_unexpected
);

    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OUT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STALL_LVL = FIFO_DEPTH - STALL_MARGIN;

    yw_state_e         r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ROW_W-1:0]  r_count;
    logic [ROW_W-1:0]  r_issued;
    logic [OUT_W-1:0]  r_outstanding;

    logic              r_stall;
    logic              r_req_st;
    logic [ADDR_W-1:0] r_req_vadr;
    logic [DBL_W-1:0]  r_req_wrd;
    logic              r_busy;
    logic              r_done;
    logic              r_err_overflow;
    logic              r_err_unexpected;

    logic              w_run;
    logic              w_start_ok;
    logic              w_fifo_wr;
    logic              w_pop;
    logic              w_cmp_take;
    logic [FP_W-1:0]   w_fifo_rd_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_fifo_afull;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_unused;

    assign w_run      = (r_state == ST_RUN);
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_fifo_wr  = push_to_y && w_run && !w_fifo_full;

    // A row leaves the buffer only when the MC can take it and the pass still needs it.
    assign w_pop = w_run && !w_fifo_empty && !mc_wr_rq_stall
                 && (r_outstanding < OUT_W'(MAX_OUTSTANDING))
                 && (r_issued < r_count);

    // Completions with nothing in flight (e.g. after a mid-pass reset) are dropped.
    assign w_cmp_take = mc_wr_cmd_cmp && (r_outstanding != '0);

    // Almost-full is not used here; stall is derived from the exact count.
    assign w_unused = w_fifo_afull;

    std_fifo #(
        .WIDTH     (FP_W),
        .DEPTH     (FIFO_DEPTH),
        .AF_THRESH (STALL_LVL)
    ) u_result_fifo (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clr         (w_start_ok),
        .i_wr_en       (w_fifo_wr),
        .i_wr_data     (v_to_y),
        .i_rd_en       (w_pop),
        .o_rd_data     (w_fifo_rd_data),
        .o_full        (w_fifo_full),
        .o_empty       (w_fifo_empty),
        .o_almost_full (w_fifo_afull),
        .o_count       (w_fifo_count)
    );

    // Controller: state, counters, store request and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_base           <= '0;
            r_count          <= '0;
            r_issued         <= '0;
            r_outstanding    <= '0;
            r_stall          <= 1'b1;
            r_req_st         <= 1'b0;
            r_req_vadr       <= '0;
            r_req_wrd        <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_err_overflow   <= 1'b0;
            r_err_unexpected <= 1'b0;
        end else begin
            r_req_st <= w_pop;
            if (w_pop) begin
                // Address index is the pop order, which equals arrival order.
                r_req_vadr <= r_base + (ADDR_W'(r_issued) << 3);
                r_req_wrd  <= flopoco_to_ieee(w_fifo_rd_data);
                r_issued   <= r_issued + ROW_W'(1);
            end

            case ({w_pop, w_cmp_take})
                2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            // Registered one cycle late; the margin absorbs the producer's in-flight rows.
            r_stall <= (w_fifo_count >= CNT_W'(STALL_LVL));

            if (push_to_y && !w_run)               r_err_unexpected <= 1'b1;
            if (push_to_y && w_run && w_fifo_full) r_err_overflow   <= 1'b1;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state          <= ST_RUN;
                        r_base           <= y_base;
                        r_count          <= row_count;
                        r_issued         <= '0;
                        r_outstanding    <= '0;
                        r_err_overflow   <= 1'b0;
                        r_err_unexpected <= 1'b0;
                        r_busy           <= 1'b1;
                        r_done           <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_issued == r_count) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall_out      = r_stall;
    assign mc_req_st      = r_req_st;
    assign mc_req_vadr    = r_req_vadr;
    assign mc_req_wrd     = r_req_wrd;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err_overflow   = r_err_overflow;
    assign err_unexpected = r_err_unexpected;

endmodule
